// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - serial frame receiver: DATA_BITS data bits LSB first, then one parity bit.
// Moore FSM; every output is a flop loaded from next-state logic.
module parity_frame_ctrl #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 x,
  input  logic                 bit_en,
  output logic                 busy,
  output logic                 done,
  output logic                 perr,
  output logic [DATA_BITS-1:0] data,
  output logic                 z
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 z_q, z_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    data_d  = data_q;
    z_d     = z_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_DATA;
          cnt_d   = '0;
          z_d     = 1'b0;
          data_d  = '0;
        end
      end
      S_DATA: begin
        // abort wins over a coincident bit, which is dropped
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_en) begin
          data_d[cnt_q] = x;
          z_d           = z_q ^ x;
          if (cnt_q == LAST_IDX) begin
            state_d = S_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_en) begin
          state_d = S_DONE;
          perr_d  = ((z_q ^ x) != ODD);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign perr = perr_q;
  assign data = data_q;
  assign z    = z_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb/tb_parity_frame_ctrl.sv - table vectors, corner sequences and random stimulus against a frame-level model.
module tb_parity_frame_ctrl;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n, start, abort, x, bit_en;
  logic busy0, done0, perr0, z0;
  logic busy1, done1, perr1, z1;
  logic [DB-1:0] data0, data1;

  parity_frame_ctrl #(.DATA_BITS(DB), .ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x(x), .bit_en(bit_en),
    .busy(busy0), .done(done0), .perr(perr0), .data(data0), .z(z0));

  parity_frame_ctrl #(.DATA_BITS(DB), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x(x), .bit_en(bit_en),
    .busy(busy1), .done(done1), .perr(perr1), .data(data1), .z(z1));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Frame-level reference: a queue of accepted bits plus a flag for the completion cycle.
  bit          m_in_frame, m_done, m_perr_even, m_perr_odd, m_z;
  logic [DB-1:0] m_data;
  bit          bq[$];

  function automatic int ones_in_queue();
    int n = 0;
    foreach (bq[i]) n += bq[i];
    return n;
  endfunction

  task automatic model_step();
    int n;
    if (!rst_n) begin
      m_in_frame = 0; m_done = 0; m_perr_even = 0; m_perr_odd = 0; m_z = 0; m_data = '0;
      bq.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_in_frame) begin
      if (start && !abort) begin
        m_in_frame = 1; bq.delete(); m_data = '0; m_z = 0;
      end
    end else if (abort) begin
      m_in_frame = 0;
    end else if (bit_en) begin
      if (bq.size() < DB) begin
        bq.push_back(x);
        m_data[bq.size()-1] = x;
        m_z = (ones_in_queue() % 2) == 1;
      end else begin
        n = ones_in_queue() + int'(x);
        m_in_frame  = 0;
        m_done      = 1;
        m_perr_even = (n % 2) != 0;
        m_perr_odd  = (n % 2) != 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("busy", 32'(busy0), 32'(m_in_frame || m_done));
    chk("done", 32'(done0), 32'(m_done));
    chk("perr", 32'(perr0), 32'(m_perr_even));
    chk("data", 32'(data0), 32'(m_data));
    chk("z", 32'(z0), 32'(m_z));
    chk("odd_busy", 32'(busy1), 32'(m_in_frame || m_done));
    chk("odd_done", 32'(done1), 32'(m_done));
    chk("odd_perr", 32'(perr1), 32'(m_perr_odd));
    chk("odd_data", 32'(data1), 32'(m_data));
  endtask

  task automatic step(input logic s, input logic a, input logic e, input logic xx);
    start = s; abort = a; bit_en = e; x = xx;
    @(posedge clk);
    model_step();
    #1;
    if (done0) done_cnt++;
    check_model();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input int gap);
    step(1, 0, 0, 0);
    for (int i = 0; i < DB; i++) begin
      repeat (gap) step(0, 0, 0, 1);
      step(0, 0, 1, d[i]);
    end
    repeat (gap) step(0, 0, 0, 0);
    step(0, 0, 1, p);
  endtask

  typedef struct {
    logic s, a, e, xx;
    logic eb, ed, ep;
    logic [DB-1:0] edata;
    logic ez;
  } vec_t;

  vec_t tv[11];

  initial begin
    tv[0]  = '{1,0,0,0, 1,0,0, 8'h00, 0};
    tv[1]  = '{0,0,1,1, 1,0,0, 8'h01, 1};
    tv[2]  = '{0,0,1,0, 1,0,0, 8'h01, 1};
    tv[3]  = '{0,0,1,1, 1,0,0, 8'h05, 0};
    tv[4]  = '{0,0,1,1, 1,0,0, 8'h0D, 1};
    tv[5]  = '{0,0,1,0, 1,0,0, 8'h0D, 1};
    tv[6]  = '{0,0,1,0, 1,0,0, 8'h0D, 1};
    tv[7]  = '{0,0,1,0, 1,0,0, 8'h0D, 1};
    tv[8]  = '{0,0,1,0, 1,0,0, 8'h0D, 1};
    tv[9]  = '{0,0,1,1, 1,1,0, 8'h0D, 1};
    tv[10] = '{1,0,0,0, 0,0,0, 8'h0D, 1};

    rst_n = 0; start = 0; abort = 0; x = 0; bit_en = 0;
    step(1, 1, 1, 1);
    step(1, 0, 1, 1);
    chk("reset_busy", 32'(busy0), 0);
    chk("reset_data", 32'(data0), 0);
    rst_n = 1;

    // good frame; last vector also shows start in the DONE cycle is ignored
    for (int i = 0; i < 11; i++) begin
      step(tv[i].s, tv[i].a, tv[i].e, tv[i].xx);
      chk($sformatf("tv%0d_busy", i), 32'(busy0), 32'(tv[i].eb));
      chk($sformatf("tv%0d_done", i), 32'(done0), 32'(tv[i].ed));
      chk($sformatf("tv%0d_perr", i), 32'(perr0), 32'(tv[i].ep));
      chk($sformatf("tv%0d_data", i), 32'(data0), 32'(tv[i].edata));
      chk($sformatf("tv%0d_z", i), 32'(z0), 32'(tv[i].ez));
    end

    // stalled good frame
    done_cnt = 0;
    send_frame(8'h0D, 1'b1, 3);
    chk("stall_done", 32'(done0), 1);
    repeat (3) step(0, 0, 0, 0);
    chk("stall_pulses", 32'(done_cnt), 1);
    chk("stall_data", 32'(data0), 32'h0D);
    chk("stall_perr", 32'(perr0), 0);

    // bad parity: even instance flags it, odd instance does not
    send_frame(8'h0D, 1'b0, 0);
    chk("bad_perr_even", 32'(perr0), 1);
    chk("bad_perr_odd", 32'(perr1), 0);
    step(0, 1, 0, 0);

    // abort after 4 bits with a coincident bit that must be dropped
    done_cnt = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_perr_hold", 32'(perr0), 1);
    chk("abort_data_partial", 32'(data0), 32'h0F);
    step(0, 0, 0, 0);
    chk("abort_no_done", 32'(done_cnt), 0);
    send_frame(8'h0D, 1'b1, 0);
    chk("after_abort_perr", 32'(perr0), 0);
    step(0, 0, 0, 0);

    // start+abort in IDLE, then start pulses mid-frame
    step(1, 1, 0, 0);
    chk("prio_idle", 32'(busy0), 0);
    done_cnt = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < DB; i++) step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("ignore_start_dones", 32'(done_cnt), 1);
    chk("ignore_start_data", 32'(data0), 32'hFF);

    // reset mid-frame, start on the first released edge
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    rst_n = 0;
    step(0, 0, 1, 1);
    chk("rst_mid_data", 32'(data0), 0);
    chk("rst_mid_z", 32'(z0), 0);
    rst_n = 1;
    step(1, 0, 0, 0);
    chk("rst_release_busy", 32'(busy0), 1);

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the number of data bits per frame; legal range 2..16.
REQ-002 The block SHALL have parameter ODD, default 0, where 0 expects even frame parity and 1 expects odd frame parity.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  synchronous, active-low reset.
REQ-005 Port start  input  1  begin a frame; honoured only in IDLE.
REQ-006 Port abort  input  1  cancel the current frame; honoured in any non-IDLE state.
REQ-007 Port x  input  1  serial bit.
REQ-008 Port bit_en  input  1  qualifies x; x is sampled only on edges where bit_en=1.
REQ-009 Port busy  output  1  high in DATA, PARITY and DONE.
REQ-010 Port done  output  1  one-cycle frame-complete pulse.
REQ-011 Port perr  output  1  parity error of the last completed frame.
REQ-012 Port data  output  DATA_BITS  captured data word of the current or last frame.
REQ-013 Port z  output  1  running XOR of the data bits accepted so far in the current frame.

Function
REQ-014 The block SHALL implement a Moore FSM with states IDLE, DATA, PARITY and DONE; all outputs SHALL be registered.
REQ-015 IDLE with start=1 and abort=0 SHALL transition to DATA and clear the bit counter, z and data; perr SHALL hold its value.
REQ-016 In DATA, each accepted bit SHALL be written to data[cnt], LSB first; SHALL toggle z when x=1; and SHALL increment cnt.
REQ-017 Acceptance of the DATA_BITS-th data bit SHALL transition to PARITY; cnt SHALL never exceed DATA_BITS-1 as an index.
REQ-018 In PARITY, an accepted bit SHALL transition to DONE and set perr = (z ^ x) != ODD; the parity bit SHALL NOT be written to data or z.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 done SHALL therefore be high in the cycle immediately following the edge that sampled the parity bit.
REQ-021 Cycles with bit_en=0 SHALL stall DATA and PARITY with no state, count or z change; there is no timeout.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 start in the DONE cycle SHALL be ignored; a new frame needs start while in IDLE.
REQ-024 abort=1 in DATA or PARITY SHALL return to IDLE at the next edge with done=0, perr unchanged, and data and z holding their partial values.
REQ-025 abort=1 in IDLE or DONE SHALL have no effect.
REQ-026 start and abort both high in IDLE SHALL leave the block in IDLE, with abort taking priority.
REQ-027 If bit_en=1 coincides with abort in DATA or PARITY, the bit SHALL be discarded.
REQ-028 data and z SHALL remain stable from DONE until the next accepted start.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, cnt=0, busy=0, done=0, perr=0, z=0 and data=0, overriding all other inputs.
REQ-030 Reset asserted mid-frame SHALL discard the frame without a done pulse.
REQ-031 Reset asserted during the DONE cycle SHALL clear done at that edge.
REQ-032 The first start SHALL be honoured on the first edge with rst_n=1.

Verification (DATA_BITS=8, ODD=0 unless stated)
REQ-033 Good frame: start, bits 1,0,1,1,0,0,0,0, parity bit 1 -> data=8'h0D, z=1, done pulse one cycle after the parity edge, perr=0.
REQ-034 Bad frame: same data bits, parity bit 0 -> done=1, perr=1; repeat with ODD=1 and parity bit 0 -> perr=0.
REQ-035 Stall: insert 3 bit_en=0 cycles between each bit of the good frame -> identical data, z and perr, with done delayed accordingly and no extra pulses.
REQ-036 Abort: abort after 4 data bits -> IDLE next cycle, busy=0, no done, perr holds its prior value; a following good frame completes normally.
REQ-037 Priority and ignore: start and abort together in IDLE -> stays IDLE; start pulsed mid-frame -> frame unaffected, single done.
REQ-038 Reset mid-frame: rst_n=0 after 5 bits -> all outputs 0 next edge; start on the first edge after release -> DATA.
